sync_fifo_ctrl: RTL and testbench
=================================

# sync_fifo_ctrl

Single-clock, parametrised FIFO with integrated register-array storage, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a selectable standard or first-word-fall-through read mode. It is the same-clock member of the FIFO controller family. It buffers bursts between producer and consumer logic in one clock domain and exposes its read/write pointers for debug.

## Interface
- DATA_WIDTH, 8: word width in bits.
- PTR_WIDTH, 4: pointer width; depth DEPTH = 2**PTR_WIDTH.
- AFULL_THRESH, DEPTH-4: o_afull asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2: o_aempty asserts when count <= this value; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  synchronous flush of pointers and count.
- i_clr_err  in  1  clears o_ovf/o_udf.
- i_wen  in  1  write request.
- i_din  in  DATA_WIDTH  write data.
- i_ren  in  1  read request.
- o_dout  out  DATA_WIDTH  read data.
- o_wptr  out  PTR_WIDTH  write pointer.
- o_rptr  out  PTR_WIDTH  read pointer.
- o_count  out  PTR_WIDTH+1  occupancy, 0..DEPTH.
- o_full, o_empty, o_afull, o_aempty  out  1 each  status flags.
- o_ovf, o_udf  out  1 each  sticky overflow/underflow.

## Operation
- Storage: DEPTH x DATA_WIDTH register array. It is not cleared by reset or flush.
- Write accepted (wacc) = i_wen & ~o_full. On wacc: mem[o_wptr] <= i_din, and o_wptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Read accepted (racc) = i_ren & ~o_empty. On racc: o_rptr increments modulo DEPTH.
- Acceptance uses only the flags present before the edge.
  - Write when full is rejected, even with a simultaneous read.
  - Read when empty is rejected, even with a simultaneous write.
- Count update:
  - +1 on wacc only.
  - -1 on racc only.
  - Unchanged on both or neither.
- Flags are combinational decodes of the registered count:
  - o_full = (count == DEPTH).
  - o_empty = (count == 0).
  - o_afull = (count >= AFULL_THRESH).
  - o_aempty = (count <= AEMPTY_THRESH).
- Errors:
  - o_ovf sets on i_wen & o_full.
  - o_udf sets on i_ren & o_empty.
  - Both hold until i_rst or i_clr_err.
  - If a set condition and i_clr_err occur in the same cycle, set wins.
- Flush:
  - Next state: o_wptr = o_rptr = count = 0.
  - Any wen/ren in the same cycle is ignored and does not set error flags.
  - o_dout and the error flags are unchanged.
- FWFT=0: on racc, o_dout <= mem[o_rptr]. Otherwise o_dout holds its last value.
- FWFT=1: o_dout = mem[o_rptr] combinationally. It is valid whenever ~o_empty and don't-care when empty; i_ren pops the displayed word.
- Priority: i_rst > i_flush > normal operation.

## Timing
- Reset values (cycle after i_rst sampled high):
  - o_wptr=0, o_rptr=0, o_count=0.
  - o_empty=1, o_full=0, o_aempty=1, o_afull=0.
  - o_ovf=0, o_udf=0.
  - o_dout=0 (FWFT=0).
- Reset mid-operation discards all contents regardless of i_wen/i_ren in that cycle.
- Write-to-empty-deassert latency: 1 cycle. o_empty falls in the cycle after the wacc edge.
- FWFT=0 read latency: data appears on o_dout 1 cycle after the racc edge.
- FWFT=1 read latency: 0. The head word is visible the cycle o_empty is low.
- Flags and count change only at the clock edge following the causing request.
- Full and empty are distinguished by count, not by pointer equality. Pointers are equal both when full and when empty.

## Test plan
- Reset then fill (DEPTH=16, FWFT=0, AFULL=12, AEMPTY=2). Write 0x00..0x0F, one per cycle:
  - o_aempty falls when count=3.
  - o_afull rises when count=12.
  - o_full=1 at count=16.
  - o_wptr wraps to 0.
- Overflow: with the FIFO full, assert i_wen with i_din=0xAA:
  - o_ovf=1, count stays 16, mem unchanged.
  - i_clr_err -> o_ovf=0 next cycle.
- Drain (FWFT=0): 16 reads return 0x00..0x0F, each 1 cycle after its racc. After that:
  - o_empty=1.
  - An extra read sets o_udf=1 and leaves o_dout=0x0F.
- Simultaneous read+write at count=5: count stays 5 and both pointers advance. At count=16, wen+ren: only the read is accepted, count=15, o_ovf=1.
- FWFT=1: write 0x3C into the empty FIFO:
  - Next cycle o_empty=0 and o_dout=0x3C, with no read issued.
  - i_ren pops it, then o_empty=1.
- Flush with count=7, i_wen=1 in the same cycle: next cycle count=0, pointers=0, o_empty=1, and o_ovf/o_udf are unchanged.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO with register-array storage, occupancy
//               count, almost-full/almost-empty thresholds, sticky
//               overflow/underflow flags, synchronous flush and a selectable
//               standard or first-word-fall-through read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int PTR_WIDTH     = 4,
    parameter int AFULL_THRESH  = (1 << PTR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_clr_err,
    input  logic                  i_wen,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_ren,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic [PTR_WIDTH-1:0]  o_wptr,
    output logic [PTR_WIDTH-1:0]  o_rptr,
    output logic [PTR_WIDTH:0]    o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_afull,
    output logic                  o_aempty,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int                 c_depth      = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] c_depth_cnt  = (PTR_WIDTH + 1)'(c_depth);
    localparam logic [PTR_WIDTH:0] c_afull_cnt  = (PTR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [PTR_WIDTH:0] c_aempty_cnt = (PTR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
    logic [PTR_WIDTH-1:0]  r_wptr;
    logic [PTR_WIDTH-1:0]  r_rptr;
    logic [PTR_WIDTH:0]    r_count;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wacc;
    logic                  w_racc;

    // Full and empty come from the count, since the pointers match in both cases.
    assign w_full  = (r_count == c_depth_cnt);
    assign w_empty = (r_count == '0);

    // Acceptance looks only at the flags from before the edge, so a read
    // cannot make room for a write in the same cycle, and the reverse holds too.
    assign w_wacc  = i_wen & ~w_full;
    assign w_racc  = i_ren & ~w_empty;

    // Pointers, occupancy and sticky error flags. Flush clears pointers and
    // count, ignores same-cycle requests and leaves the error flags alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wacc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_racc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wacc, w_racc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A new error event takes priority over a clear in the same cycle.
            if (i_wen & w_full) begin
                r_ovf <= 1'b1;
            end else if (i_clr_err) begin
                r_ovf <= 1'b0;
            end
            if (i_ren & w_empty) begin
                r_udf <= 1'b1;
            end else if (i_clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    // Storage write; the array is never cleared, only the pointers are.
    always_ff @(posedge i_clk) begin
        if (w_wacc && !i_rst && !i_flush) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // The head word is shown directly; it is meaningless while empty.
            assign o_dout = r_mem[r_rptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;

            // Registered read port: loads on an accepted read, holds otherwise.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_dout <= '0;
                end else if (!i_flush && w_racc) begin
                    r_dout <= r_mem[r_rptr];
                end
            end

            assign o_dout = r_dout;
        end
    endgenerate

    assign o_wptr   = r_wptr;
    assign o_rptr   = r_rptr;
    assign o_count  = r_count;
    assign o_full   = w_full;
    assign o_empty  = w_empty;
    assign o_afull  = (r_count >= c_afull_cnt);
    assign o_aempty = (r_count <= c_aempty_cnt);
    assign o_ovf    = r_ovf;
    assign o_udf    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctrl
// Description : Self-checking bench for sync_fifo_ctrl. A standard-read and a
//               first-word-fall-through instance share one stimulus stream
//               and are compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, flush, clr_err, wen, ren;
    logic [7:0] din;

    logic [7:0] std_dout, fw_dout;
    logic [3:0] std_wptr, std_rptr, fw_wptr, fw_rptr;
    logic [4:0] std_count, fw_count;
    logic       std_full, std_empty, std_afull, std_aempty, std_ovf, std_udf;
    logic       fw_full, fw_empty, fw_afull, fw_aempty, fw_ovf, fw_udf;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a queue, pointers as plain write/read tallies.
    logic [7:0] mq[$];
    int         m_wp, m_rp;
    bit         m_ovf, m_udf;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(4), .AFULL_THRESH(12),
                     .AEMPTY_THRESH(2), .FWFT(1'b0)) dut_std (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_clr_err(clr_err),
        .i_wen(wen), .i_din(din), .i_ren(ren), .o_dout(std_dout),
        .o_wptr(std_wptr), .o_rptr(std_rptr), .o_count(std_count),
        .o_full(std_full), .o_empty(std_empty), .o_afull(std_afull),
        .o_aempty(std_aempty), .o_ovf(std_ovf), .o_udf(std_udf));

    sync_fifo_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(4), .AFULL_THRESH(12),
                     .AEMPTY_THRESH(2), .FWFT(1'b1)) dut_fw (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_clr_err(clr_err),
        .i_wen(wen), .i_din(din), .i_ren(ren), .o_dout(fw_dout),
        .o_wptr(fw_wptr), .o_rptr(fw_rptr), .o_count(fw_count),
        .o_full(fw_full), .o_empty(fw_empty), .o_afull(fw_afull),
        .o_aempty(fw_aempty), .o_ovf(fw_ovf), .o_udf(fw_udf));

    wire [18:0] w_std_status = {std_count, std_full, std_empty, std_afull, std_aempty,
                                std_ovf, std_udf, std_wptr, std_rptr};
    wire [18:0] w_fw_status  = {fw_count, fw_full, fw_empty, fw_afull, fw_aempty,
                                fw_ovf, fw_udf, fw_wptr, fw_rptr};

    function automatic logic [18:0] exp_status();
        return {5'(mq.size()), mq.size() == 16, mq.size() == 0, mq.size() >= 12,
                mq.size() <= 2, m_ovf, m_udf, 4'(m_wp), 4'(m_rp)};
    endfunction

    // Apply one cycle of stimulus, advance the model across the edge, then
    // leave time at edge+1 for sampling.
    task automatic drive(input bit w, input logic [7:0] d, input bit r,
                         input bit fl, input bit clr, input bit rs);
        bit was_full, was_empty;
        wen = w; din = d; ren = r; flush = fl; clr_err = clr; rst = rs;
        @(posedge clk);
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (rs) begin
            mq.delete(); m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0; m_dout = 8'h00;
        end else if (fl) begin
            mq.delete(); m_wp = 0; m_rp = 0;
        end else begin
            if (r && !was_empty) begin
                m_dout = mq.pop_front();
                m_rp   = (m_rp + 1) % 16;
            end
            if (w && !was_full) begin
                mq.push_back(d);
                m_wp = (m_wp + 1) % 16;
            end
            m_ovf = (w && was_full)  ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_udf = (r && was_empty) ? 1'b1 : (clr ? 1'b0 : m_udf);
        end
        #1;
        wen = 0; ren = 0; flush = 0; clr_err = 0; rst = 0;
    endtask

    task automatic test_reset();
        drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (std_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", std_count); end
        n_cmp++; if (std_wptr !== 4'd0 || std_rptr !== 4'd0) begin n_err++; $display("FAIL reset_ptrs: got w=%0d r=%0d want 0/0", std_wptr, std_rptr); end
        n_cmp++; if ({std_empty, std_full, std_aempty, std_afull} !== 4'b1010) begin n_err++; $display("FAIL reset_flags: got e/f/ae/af=%b want 1010", {std_empty, std_full, std_aempty, std_afull}); end
        n_cmp++; if ({std_ovf, std_udf} !== 2'b00) begin n_err++; $display("FAIL reset_err: got ovf/udf=%b want 00", {std_ovf, std_udf}); end
        n_cmp++; if (std_dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", std_dout); end
        n_cmp++; if (w_fw_status !== exp_status()) begin n_err++; $display("FAIL reset_fwft_status: got %h want %h", w_fw_status, exp_status()); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (std_count !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count: got %0d want %0d", std_count, i + 1); end
            n_cmp++; if (std_aempty !== (i + 1 <= 2)) begin n_err++; $display("FAIL fill_aempty: got %b want %b at count %0d", std_aempty, (i + 1 <= 2), i + 1); end
            n_cmp++; if (std_afull !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_afull: got %b want %b at count %0d", std_afull, (i + 1 >= 12), i + 1); end
            n_cmp++; if (std_full !== (i + 1 == 16)) begin n_err++; $display("FAIL fill_full: got %b want %b at count %0d", std_full, (i + 1 == 16), i + 1); end
            n_cmp++; if (std_wptr !== 4'((i + 1) % 16)) begin n_err++; $display("FAIL fill_wptr: got %0d want %0d", std_wptr, (i + 1) % 16); end
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (std_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", std_ovf); end
        n_cmp++; if (std_count !== 5'd16 || std_wptr !== 4'd0) begin n_err++; $display("FAIL ovf_hold: got count=%0d wptr=%0d want 16/0", std_count, std_wptr); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (std_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", std_ovf); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (fw_dout !== 8'(i)) begin n_err++; $display("FAIL drain_fwft_head: got %h want %h", fw_dout, 8'(i)); end
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (std_dout !== 8'(i)) begin n_err++; $display("FAIL drain_dout: got %h want %h", std_dout, 8'(i)); end
        end
        n_cmp++; if (std_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", std_empty); end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (std_udf !== 1'b1) begin n_err++; $display("FAIL udf_set: got %b want 1", std_udf); end
        n_cmp++; if (std_dout !== 8'h0F) begin n_err++; $display("FAIL udf_dout_hold: got %h want 0f", std_dout); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] wp0, rp0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        wp0 = std_wptr; rp0 = std_rptr;
        drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (std_count !== 5'd5) begin n_err++; $display("FAIL rw5_count: got %0d want 5", std_count); end
        n_cmp++; if (std_wptr !== wp0 + 4'd1 || std_rptr !== rp0 + 4'd1) begin n_err++; $display("FAIL rw5_ptrs: got w=%0d r=%0d want %0d/%0d", std_wptr, std_rptr, wp0 + 4'd1, rp0 + 4'd1); end
        n_cmp++; if (std_dout !== m_dout) begin n_err++; $display("FAIL rw5_dout: got %h want %h", std_dout, m_dout); end
        for (int i = 0; i < 11; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (std_count !== 5'd15 || std_ovf !== 1'b1) begin n_err++; $display("FAIL rw16: got count=%0d ovf=%b want 15/1", std_count, std_ovf); end
        n_cmp++; if (w_std_status !== exp_status()) begin n_err++; $display("FAIL rw16_status: got %h want %h", w_std_status, exp_status()); end
    endtask

    task automatic test_fwft();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fw_empty !== 1'b0 || fw_dout !== 8'h3C) begin n_err++; $display("FAIL fwft_show: got empty=%b dout=%h want 0/3c", fw_empty, fw_dout); end
        n_cmp++; if (std_dout !== 8'h00) begin n_err++; $display("FAIL std_no_read: got %h want 00", std_dout); end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fw_empty !== 1'b1) begin n_err++; $display("FAIL fwft_pop: got empty=%b want 1", fw_empty); end
        n_cmp++; if (std_dout !== 8'h3C) begin n_err++; $display("FAIL std_pop: got %h want 3c", std_dout); end
    endtask

    task automatic test_flush();
        logic [7:0] d0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        d0 = m_dout;
        n_cmp++; if (std_count !== 5'd7) begin n_err++; $display("FAIL flush_pre_count: got %0d want 7", std_count); end
        drive(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (std_count !== 5'd0 || std_wptr !== 4'd0 || std_rptr !== 4'd0 || std_empty !== 1'b1) begin n_err++; $display("FAIL flush_state: got count=%0d w=%0d r=%0d empty=%b want 0/0/0/1", std_count, std_wptr, std_rptr, std_empty); end
        n_cmp++; if ({std_ovf, std_udf} !== 2'b01) begin n_err++; $display("FAIL flush_err: got ovf/udf=%b want 01", {std_ovf, std_udf}); end
        n_cmp++; if (std_dout !== d0) begin n_err++; $display("FAIL flush_dout: got %h want %h", std_dout, d0); end
    endtask

    task automatic test_random();
        int wbias;
        for (int i = 0; i < 600; i++) begin
            wbias = ((i / 60) % 2 == 0) ? 75 : 30;
            drive($urandom_range(99) < wbias, 8'($urandom), $urandom_range(99) < 100 - wbias,
                  $urandom_range(59) == 0, $urandom_range(19) == 0, $urandom_range(199) == 0);
            n_cmp++; if (w_std_status !== exp_status()) begin n_err++; $display("FAIL rand_std_status: cycle %0d got %h want %h", i, w_std_status, exp_status()); end
            n_cmp++; if (w_fw_status !== exp_status()) begin n_err++; $display("FAIL rand_fwft_status: cycle %0d got %h want %h", i, w_fw_status, exp_status()); end
            n_cmp++; if (std_dout !== m_dout) begin n_err++; $display("FAIL rand_std_dout: cycle %0d got %h want %h", i, std_dout, m_dout); end
            if (mq.size() != 0) begin
                n_cmp++; if (fw_dout !== mq[0]) begin n_err++; $display("FAIL rand_fwft_dout: cycle %0d got %h want %h", i, fw_dout, mq[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; clr_err = 1'b0; wen = 1'b0; ren = 1'b0; din = 8'h00;
        m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0; m_dout = 8'h00;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_fwft();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
